// File: rtl/exp_seq_controller_pkg.sv
// Shared definitions for the exponential-engine sequencing controller:
// controller state encoding, operand word layout and word widths.
package exp_seq_controller_pkg;

  localparam int OP_W   = 18;  // operand word popped from the input FIFO
  localparam int RES_W  = 21;  // engine result word pushed to the output FIFO
  localparam int VO_MSB = 17;
  localparam int VO_LSB = 2;
  localparam int UI_MSB = 1;
  localparam int VO_W   = VO_MSB - VO_LSB + 1;
  localparam int UI_W   = UI_MSB + 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_START  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_WRITE  = 3'd5,
    ST_FINISH = 3'd6
  } state_t;

  // Counter width able to hold values up to n (at least one bit).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/exp_seq_controller_if.sv
// Job request, operand FIFO, datapath strobe and result FIFO signals of the
// controller.
// Handshakes: start is a single-cycle request honoured only while idle;
// in_rd pops the first-word-fall-through operand FIFO in a cycle where
// in_empty=0; out_wr pushes the result FIFO in a cycle where out_full=0;
// engStart/engDone bracket one engine run, engDone is only observed while
// the controller waits for it.
interface exp_seq_controller_if #(parameter int CNT_W = 8);
  import exp_seq_controller_pkg::*;

  logic              start;
  logic [CNT_W-1:0]  num;
  logic              in_empty;
  logic [OP_W-1:0]   in_data;
  logic              in_rd;
  logic [VO_W-1:0]   Vo;
  logic [UI_W-1:0]   Ui;
  logic              Ldx;
  logic              Ldu;
  logic              shiftL;
  logic              engStart;
  logic              engDone;
  logic              out_full;
  logic              out_wr;
  logic              busy;
  logic              done;

  // Controller side.
  modport master (
    input  start, num, in_empty, in_data, engDone, out_full,
    output in_rd, Vo, Ui, Ldx, Ldu, shiftL, engStart, out_wr, busy, done
  );

  // Environment side (FIFOs, datapath, job requester).
  modport slave (
    output start, num, in_empty, in_data, engDone, out_full,
    input  in_rd, Vo, Ui, Ldx, Ldu, shiftL, engStart, out_wr, busy, done
  );

endinterface

// File: rtl/exp_seq_controller_down_counter.sv
// Loadable down counter with a zero flag; saturates at zero.
module exp_seq_controller_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load has priority over decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register, cleared by the asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/exp_seq_controller.sv
// Sequences one job of num operands through the exponential engine:
// pop operand, load datapath, pre-scale by SHIFT_N shifts, run the engine,
// push the result, repeat; then pulse done.
module exp_seq_controller
  import exp_seq_controller_pkg::*;
#(
  parameter int SHIFT_N = 0,
  parameter int CNT_W   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  exp_seq_controller_if.master        bus,
  output state_t                      state_o
);

  localparam int SH_W = cnt_width(SHIFT_N);
  // The shift counter holds the shifts still to do after the current one,
  // so the last SHIFT cycle is the one where it reads zero.
  localparam logic [SH_W-1:0] SH_LOAD = SH_W'((SHIFT_N > 0) ? SHIFT_N - 1 : 0);

  state_t state_q;
  logic   fetch_go;
  logic   write_go;
  logic   rem_zero;
  logic   sh_zero;

  assign fetch_go = (state_q == ST_FETCH) && !bus.in_empty;
  assign write_go = (state_q == ST_WRITE) && !bus.out_full;

  // remaining holds the elements still to process after the current one,
  // loaded with num-1 so the zero flag marks the last element directly and
  // num = 2^CNT_W-1 never needs an extra bit.
  exp_seq_controller_down_counter #(.W(CNT_W)) u_remaining (
    .clk        (clk),
    .rst        (rst),
    .load_i     ((state_q == ST_IDLE) && bus.start),
    .load_val_i (bus.num - CNT_W'(1)),
    .dec_i      (write_go),
    .zero_o     (rem_zero)
  );

  exp_seq_controller_down_counter #(.W(SH_W)) u_shift_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (fetch_go),
    .load_val_i (SH_LOAD),
    .dec_i      (state_q == ST_SHIFT),
    .zero_o     (sh_zero)
  );

  // Controller state machine; start and engDone only matter in IDLE / WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q <= (bus.num == '0) ? ST_FINISH : ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (!bus.in_empty) begin
            state_q <= (SHIFT_N > 0) ? ST_SHIFT : ST_START;
          end
        end
        ST_SHIFT: begin
          if (sh_zero) begin
            state_q <= ST_START;
          end
        end
        ST_START: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (bus.engDone) begin
            state_q <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (!bus.out_full) begin
            state_q <= rem_zero ? ST_FINISH : ST_FETCH;
          end
        end
        ST_FINISH: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  // Operand fields pass straight through to the datapath.
  assign bus.Vo = bus.in_data[VO_MSB:VO_LSB];
  assign bus.Ui = bus.in_data[UI_MSB:0];

  // Pop and both loads happen together in the cycle the FIFO offers a word.
  assign bus.in_rd = fetch_go;
  assign bus.Ldx   = fetch_go;
  assign bus.Ldu   = fetch_go;

  // Remaining strobes depend on the state register only.
  assign bus.shiftL   = (state_q == ST_SHIFT);
  assign bus.engStart = (state_q == ST_START);
  assign bus.out_wr   = write_go;
  assign bus.done     = (state_q == ST_FINISH);
  // busy drops in the done cycle so a requester sees done with busy low.
  assign bus.busy     = (state_q != ST_IDLE) && (state_q != ST_FINISH);

  assign state_o = state_q;

endmodule

// File: tb/tb_exp_seq_controller.sv
// Bench for exp_seq_controller: operand FIFO, engine and result FIFO models
// around the controller, plus a job-level reference model checked at every
// falling clock edge.
module tb_exp_seq_controller;
  import exp_seq_controller_pkg::*;

  localparam int SHIFT_N = 3;
  localparam int CNT_W   = 8;
  localparam int FIFO_D  = 4096;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;

  always #5 clk = ~clk;

  exp_seq_controller_if #(.CNT_W(CNT_W)) bus ();

  exp_seq_controller #(.SHIFT_N(SHIFT_N), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Result the datapath produces for one operand: x pre-scaled by SHIFT_N
  // shifts, folded with Ui.
  function automatic logic [RES_W-1:0] calc_result(input logic [VO_W-1:0] vo,
                                                   input logic [UI_W-1:0] ui);
    return (RES_W'(vo) << SHIFT_N) ^ RES_W'(ui);
  endfunction

  // ---------------- environment state ----------------
  logic [OP_W-1:0]  words [0:FIFO_D-1];
  int               wr_ptr = 0;       // written by driver tasks only
  int               rd_ptr = 0;       // written by the environment only
  int               lat_min = 5;
  int               lat_max = 5;
  bit               rand_stall = 1'b0;
  int               out_hold_len = 0;
  int               spur_req = 0;
  int               spur_ack = 0;
  logic [RES_W-1:0] wr_data = '0;

  // Written by the monitor, read by the environment.
  logic             rd_seen = 1'b0;
  logic             es_seen = 1'b0;
  logic [VO_W-1:0]  x_vo = '0;
  logic [UI_W-1:0]  x_ui = '0;

  // ---------------- reference model state ----------------
  typedef enum int {P_NONE, P_FETCH, P_PIPE, P_ENG, P_WRITE} phase_t;
  phase_t           ph = P_NONE;
  int               pipe_t = 0;
  int               left = 0;
  int               job_num = 0;
  int               job_rd = 0;
  int               job_wr = 0;
  int               es_count = 0;
  int               jobs_done = 0;
  logic             done_due = 1'b0;
  logic [RES_W-1:0] exp_q [$];

  // Environment: FIFO pop, engine latency and result hold, output back-pressure.
  initial begin : env
    int   eng_t;
    int   out_cnt;
    logic prev_eng;
    logic in_hold;
    eng_t        = 0;
    out_cnt      = 0;
    bus.in_empty = 1'b1;
    bus.in_data  = '0;
    bus.engDone  = 1'b0;
    bus.out_full = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      prev_eng = bus.engDone;
      if (!rst) begin
        rd_ptr       = wr_ptr;
        eng_t        = 0;
        out_cnt      = 0;
        spur_ack     = spur_req;
        bus.engDone  = 1'b0;
        bus.out_full = 1'b0;
      end else begin
        if (rd_seen) rd_ptr++;
        if (es_seen) eng_t = $urandom_range(lat_max, lat_min);
        else if (eng_t > 0) eng_t--;
        bus.engDone = (eng_t == 1);
        if (eng_t == 1) wr_data = calc_result(x_vo, x_ui);
        if (spur_ack != spur_req) begin
          bus.engDone = 1'b1;
          spur_ack    = spur_req;
        end
        if (prev_eng && (out_hold_len > 0)) out_cnt = out_hold_len;
        if (out_cnt > 0) begin
          bus.out_full = 1'b1;
          out_cnt--;
        end else begin
          bus.out_full = rand_stall ? ($urandom_range(0, 2) == 0) : 1'b0;
        end
      end
      in_hold      = rand_stall && ($urandom_range(0, 3) == 0);
      bus.in_empty = (rd_ptr == wr_ptr) || in_hold;
      bus.in_data  = (rd_ptr != wr_ptr) ? words[rd_ptr % FIFO_D] : '0;
    end
  end

  // Monitor / scoreboard: compares every strobe against the job model.
  always @(negedge clk) begin : monitor
    logic exp_rd, exp_sh, exp_es, exp_wr, done_now;
    if (!rst) begin
      ph       = P_NONE;
      done_due = 1'b0;
      rd_seen  = 1'b0;
      es_seen  = 1'b0;
      exp_q.delete();
    end else begin
      exp_rd = (ph == P_FETCH) && !bus.in_empty;
      exp_sh = (ph == P_PIPE) && (pipe_t < SHIFT_N);
      exp_es = (ph == P_PIPE) && (pipe_t == SHIFT_N);
      exp_wr = (ph == P_WRITE) && !bus.out_full;
      chk("in_rd",    bus.in_rd,    exp_rd);
      chk("Ldx",      bus.Ldx,      exp_rd);
      chk("Ldu",      bus.Ldu,      exp_rd);
      chk("shiftL",   bus.shiftL,   exp_sh);
      chk("engStart", bus.engStart, exp_es);
      chk("out_wr",   bus.out_wr,   exp_wr);
      chk("busy",     bus.busy,     ph != P_NONE);
      chk("done",     bus.done,     done_due);
      if (bus.in_rd) begin
        chk("Vo", bus.Vo, bus.in_data[17:2]);
        chk("Ui", bus.Ui, bus.in_data[1:0]);
        job_rd++;
      end
      if (bus.Ldx) begin
        x_vo = bus.Vo;
        x_ui = bus.Ui;
      end
      if (bus.engStart) es_count++;
      if (bus.out_wr) begin
        job_wr++;
        if (exp_q.size() == 0) chk("wr_unexpected", bus.out_wr, 1'b0);
        else chk("wr_data", wr_data, exp_q.pop_front());
      end
      rd_seen  = bus.in_rd;
      es_seen  = bus.engStart;
      done_now = done_due;
      done_due = 1'b0;
      case (ph)
        P_NONE: begin
          if (bus.start && !done_now) begin
            job_num = bus.num;
            left    = bus.num;
            job_rd  = 0;
            job_wr  = 0;
            if (bus.num == '0) done_due = 1'b1;
            else ph = P_FETCH;
          end
        end
        P_FETCH: begin
          if (exp_rd) begin
            exp_q.push_back(calc_result(bus.in_data[17:2], bus.in_data[1:0]));
            ph     = P_PIPE;
            pipe_t = 0;
          end
        end
        P_PIPE: begin
          if (exp_es) ph = P_ENG;
          else pipe_t++;
        end
        P_ENG: if (bus.engDone) ph = P_WRITE;
        P_WRITE: begin
          if (exp_wr) begin
            left--;
            if (left == 0) begin
              ph       = P_NONE;
              done_due = 1'b1;
            end else begin
              ph = P_FETCH;
            end
          end
        end
        default: ph = P_NONE;
      endcase
      if (done_now) begin
        chk("job_rd_count", job_rd, job_num);
        chk("job_wr_count", job_wr, job_num);
        chk("exp_q_drained", exp_q.size(), 0);
        jobs_done++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      words[wr_ptr % FIFO_D] = OP_W'($urandom());
      wr_ptr++;
    end
  endtask

  task automatic pulse_start(input int n);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.num   = CNT_W'(n);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!((ph == P_NONE) && !done_due) && (n < budget)) begin
      @(posedge clk);
      n++;
    end
    chk("idle_reached", (ph == P_NONE) && !done_due, 1'b1);
  endtask

  task automatic run_job(input int n, input int budget);
    push_words(n);
    pulse_start(n);
    wait_idle(budget);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int base_jobs;
    int base_es;
    int n;
    int k;
    bus.start = 1'b0;
    bus.num   = '0;
    rst       = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("reset_outputs", {bus.in_rd, bus.Ldx, bus.Ldu, bus.shiftL, bus.engStart,
                          bus.out_wr, bus.busy, bus.done}, 8'h00);
    chk("reset_state", dbg_state, ST_IDLE);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;

    // Three elements, engine answers 5 cycles after engStart.
    base_jobs = jobs_done;
    run_job(3, 200);
    chk("job3_done_once", jobs_done - base_jobs, 1);

    // Empty job: done pulse without busy, FIFO untouched.
    base_jobs = jobs_done;
    run_job(0, 20);
    chk("job0_done_once", jobs_done - base_jobs, 1);

    // Single element through the SHIFT_N pre-scale.
    run_job(1, 100);

    // Input FIFO empty for the first fetch, result FIFO full for 6 cycles.
    out_hold_len = 6;
    pulse_start(2);
    repeat (4) @(posedge clk);
    push_words(2);
    wait_idle(300);
    out_hold_len = 0;

    // start during a job and a spurious engDone while fetching are ignored.
    pulse_start(3);
    repeat (2) @(posedge clk);
    spur_req++;
    repeat (3) @(posedge clk);
    pulse_start(9);
    push_words(3);
    wait_idle(300);

    // Reset in WAIT of element 2 of 4 aborts the job.
    lat_min = 8;
    lat_max = 8;
    base_es = es_count;
    push_words(4);
    pulse_start(4);
    n = 0;
    while ((es_count - base_es < 2) && (n < 300)) begin
      @(posedge clk);
      n++;
    end
    chk("second_engStart_seen", es_count - base_es, 2);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("abort_outputs", {bus.in_rd, bus.Ldx, bus.Ldu, bus.shiftL, bus.engStart,
                          bus.out_wr, bus.busy, bus.done}, 8'h00);
    chk("abort_state", dbg_state, ST_IDLE);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    push_words(1);
    repeat (6) @(posedge clk);
    base_jobs = jobs_done;
    lat_min = 2;
    lat_max = 2;
    pulse_start(1);
    wait_idle(100);
    chk("post_reset_job", jobs_done - base_jobs, 1);

    // Randomised jobs with random stalls and engine latency.
    rand_stall = 1'b1;
    lat_min    = 1;
    lat_max    = 6;
    for (int j = 0; j < 25; j++) begin
      n = $urandom_range(0, 6);
      k = $urandom_range(0, n);
      push_words(k);
      pulse_start(n);
      repeat ($urandom_range(0, 5)) @(posedge clk);
      push_words(n - k);
      wait_idle(2000);
    end
    rand_stall = 1'b0;
    repeat (2) @(posedge clk);

    // Largest count: 255 elements with no wrap.
    lat_min   = 1;
    lat_max   = 1;
    base_jobs = jobs_done;
    run_job(255, 5000);
    chk("max_count_job", jobs_done - base_jobs, 1);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/exp_seq_controller.md
EXP_SEQ_CONTROLLER -- requirements
Module: exp_seq_controller

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  SHIFT_N  0  shiftL cycles applied after each load (pre-scale of x)
  CNT_W    8  width of element count
REQ-002 Ports, one per line (name  direction  width  meaning):
  clk       in   1      single clock, rising edge
  rst       in   1      asynchronous, active-low reset
  start     in   1      one-cycle request to process num elements
  num       in   CNT_W  element count, sampled with start
  in_empty  in   1      operand FIFO empty (first-word-fall-through)
  in_data   in   18     operand word: [17:2] Vo, [1:0] Ui
  in_rd     out  1      pop operand FIFO
  Vo        out  16     = in_data[17:2], combinational
  Ui        out  2      = in_data[1:0], combinational
  Ldx       out  1      load Vo into datapath shift register
  Ldu       out  1      load Ui into datapath Ui register
  shiftL    out  1      shift datapath x register one place
  engStart  out  1      one-cycle exponential engine start
  engDone   in   1      engine result valid on datapath wr_data
  out_full  in   1      result FIFO full
  out_wr    out  1      push datapath wr_data (21 b) into result FIFO
  busy      out  1      job in progress
  done      out  1      one-cycle job-complete pulse

Function
REQ-003 FSM states: IDLE, FETCH, SHIFT, START, WAIT, WRITE, FINISH.
REQ-004 IDLE: start=1, num!=0 -> latch remaining=num, go FETCH; start=1, num=0 -> FINISH.
REQ-005 start SHALL be ignored in every state except IDLE.
REQ-006 FETCH: while in_empty=1 hold, all strobes 0; when in_empty=0 assert in_rd, Ldx, Ldu together for exactly one cycle, then SHIFT if SHIFT_N>0, else START.
REQ-007 SHIFT: shiftL=1 for exactly SHIFT_N consecutive cycles (shift counter), then START.
REQ-008 START: engStart=1 for one cycle, then WAIT.
REQ-009 WAIT: stay until engDone=1 sampled; next state WRITE; engDone in any other state SHALL be ignored.
REQ-010 WRITE: while out_full=1 hold with out_wr=0; when out_full=0 assert out_wr one cycle, decrement remaining; remaining was 1 -> FINISH, else FETCH.
REQ-011 FINISH: done=1 for one cycle, then IDLE.
REQ-012 busy=1 in every state except IDLE; busy=0 in the cycle done=1 and not asserted for num=0 jobs.
REQ-013 in_rd, Ldx, Ldu are Mealy (FETCH and !in_empty); all other strobes decoded from state only.
REQ-014 Per-element latency without stalls: 1 (FETCH) + SHIFT_N + 1 (START) + WAIT cycles + 1 (WRITE).
REQ-015 Exactly one in_rd and one out_wr per element; never two strobes of the same kind in consecutive cycles.
REQ-016 remaining is CNT_W bits unsigned; num = 2^CNT_W-1 SHALL process that many elements with no wrap.
REQ-017 Engine result SHALL be held on wr_data from engDone until the next engStart; the controller relies on this during WRITE stalls.

Reset
REQ-018 rst=0 asynchronously forces IDLE, remaining=0, shift counter=0; all outputs except Vo/Ui =0.
REQ-019 Reset mid-job aborts it: no done, no out_wr, no in_rd until a new start after release.

Structure
REQ-020 Shared header: state encodings, operand field positions (VO_MSB=17, VO_LSB=2, UI_MSB=1), word widths 18 and 21.
REQ-021 One sub-module: down_counter (load, decrement, zero flag), instantiated for remaining and shift count.
REQ-022 Controller instantiated beside wrapper_datapath; its strobes connect one-to-one to Ldx, Ldu, shiftL, engStart, engDone.

Verification
REQ-023 num=3, FIFO holds 3 words, engDone 5 cycles after engStart, out_full=0 -> 3 in_rd, 3 out_wr, done once, busy back to 0.
REQ-024 start with num=0 -> done pulse 2 cycles later, busy never 1, no in_rd/out_wr.
REQ-025 SHIFT_N=3, num=1 -> shiftL high exactly 3 cycles between Ldx and engStart.
REQ-026 in_empty=1 for 4 cycles in FETCH, out_full=1 for 6 cycles in WRITE -> no strobes while stalled, out_wr carries held wr_data.
REQ-027 rst=0 asserted in WAIT of element 2 of 4 -> outputs 0 immediately; new start num=1 completes normally.
REQ-028 start pulsed during busy and spurious engDone in FETCH -> both ignored; counts unchanged.
